// File: rtl/alu_exec_pkg.sv
// Shared constants and the internal operation encoding for the execute stage.
package alu_exec_pkg;

  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 4;

  // ALUOp classes driven by the control unit
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 3'b111;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI    = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_ANDI   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'b011;

  // R-type funct field values
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'h02;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 4'h0,
    OP_OR      = 4'h1,
    OP_NOR     = 4'h2,
    OP_ADD     = 4'h3,
    OP_SUB     = 4'h4,
    OP_SLL     = 4'h5,
    OP_SRL     = 4'h6,
    OP_LUI     = 4'h7,
    OP_ILLEGAL = 4'hF
  } alu_op_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU-control decode: ALUOp class plus funct field to operation.
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output alu_op_e            op_c
);

  always_comb begin
    op_c = OP_ILLEGAL;
    case (alu_op)
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: op_c = OP_ADD;
          FUNCT_SUB: op_c = OP_SUB;
          FUNCT_AND: op_c = OP_AND;
          FUNCT_OR:  op_c = OP_OR;
          FUNCT_NOR: op_c = OP_NOR;
          FUNCT_SLL: op_c = OP_SLL;
          FUNCT_SRL: op_c = OP_SRL;
          default:   op_c = OP_ILLEGAL;
        endcase
      end
      ALUOP_ADDI:   op_c = OP_ADD;
      ALUOP_ORI:    op_c = OP_OR;
      ALUOP_ANDI:   op_c = OP_AND;
      ALUOP_BRANCH: op_c = OP_SUB;
      ALUOP_LUI:    op_c = OP_LUI;
      default:      op_c = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered MIPS execute stage: ALU-control decode, ALU, branch decision.
// Define ALU_OVERFLOW_EN to add a registered signed-overflow output.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_Valid,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [FUNCT_W-1:0] ALUFunction,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               BranchEQ,
  input  logic               BranchNE,
  output logic               out_Valid,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               Branch,
`ifdef ALU_OVERFLOW_EN
  output logic               Overflow,
`endif
  output logic               Illegal
);

  alu_op_e          op_c;
  logic [WIDTH-1:0] result_c;
  logic             zero_c;
  logic             branch_c;
  logic             illegal_c;

  alu_op_decode u_decode (
    .alu_op (ALUOp),
    .funct  (ALUFunction),
    .op_c   (op_c)
  );

  always_comb begin
    result_c = '0;
    case (op_c)
      OP_AND:  result_c = A & B;
      OP_OR:   result_c = A | B;
      OP_NOR:  result_c = ~(A | B);
      OP_ADD:  result_c = A + B;
      OP_SUB:  result_c = A - B;
      OP_SLL:  result_c = B << Shamt;
      OP_SRL:  result_c = B >> Shamt;
      OP_LUI:  result_c = WIDTH'({B[15:0], 16'h0000});
      default: result_c = '0;
    endcase
  end

  // Illegal ops report Zero=1 but must never take a branch
  assign illegal_c = (op_c == OP_ILLEGAL);
  assign zero_c    = (result_c == '0);
  assign branch_c  = ~illegal_c & ((BranchEQ & zero_c) | (BranchNE & ~zero_c));

`ifdef ALU_OVERFLOW_EN
  logic overflow_c;

  always_comb begin
    overflow_c = 1'b0;
    case (op_c)
      OP_ADD:  overflow_c = (A[WIDTH-1] == B[WIDTH-1]) && (result_c[WIDTH-1] != A[WIDTH-1]);
      OP_SUB:  overflow_c = (A[WIDTH-1] != B[WIDTH-1]) && (result_c[WIDTH-1] != A[WIDTH-1]);
      default: overflow_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Overflow <= 1'b0;
    else     Overflow <= overflow_c;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_Valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Branch    <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      out_Valid <= in_Valid;
      ALUResult <= result_c;
      Zero      <= zero_c;
      Branch    <= branch_c;
      Illegal   <= illegal_c;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_Valid;
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic [4:0]  Shamt;
  logic [31:0] A;
  logic [31:0] B;
  logic        BranchEQ;
  logic        BranchNE;
  logic        out_Valid;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Branch;
  logic        Illegal;
`ifdef ALU_OVERFLOW_EN
  logic        Overflow;
`endif

  int n_vec;
  int n_err;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_Valid    (in_Valid),
    .ALUOp       (ALUOp),
    .ALUFunction (ALUFunction),
    .Shamt       (Shamt),
    .A           (A),
    .B           (B),
    .BranchEQ    (BranchEQ),
    .BranchNE    (BranchNE),
    .out_Valid   (out_Valid),
    .ALUResult   (ALUResult),
    .Zero        (Zero),
    .Branch      (Branch),
`ifdef ALU_OVERFLOW_EN
    .Overflow    (Overflow),
`endif
    .Illegal     (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic beq, input logic bne);
    in_Valid = v; ALUOp = op; ALUFunction = fn; Shamt = sh;
    A = a; B = b; BranchEQ = beq; BranchNE = bne;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [31:0] res,
                            input logic z, input logic br, input logic ill);
    check({tag, ".valid"}, 32'(out_Valid), 32'(v));
    check({tag, ".result"}, ALUResult, res);
    check({tag, ".zero"}, 32'(Zero), 32'(z));
    check({tag, ".branch"}, 32'(Branch), 32'(br));
    check({tag, ".illegal"}, 32'(Illegal), 32'(ill));
  endtask

  // Apply one vector, clock it in, sample just after the edge.
  task automatic vec(input string tag, input logic v, input logic [2:0] op,
                     input logic [5:0] fn, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic beq, input logic bne,
                     input logic [31:0] res, input logic z, input logic br, input logic ill);
    drive(v, op, fn, sh, a, b, beq, bne);
    @(posedge clk);
    #1;
    check_outs(tag, v, res, z, br, ill);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 3'b000, 6'h00, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_init", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // R-type, A=5 B=3
    vec("add",  1, 3'b111, 6'h20, 0, 32'd5, 32'd3, 0, 0, 32'd8, 0, 0, 0);
    vec("sub",  1, 3'b111, 6'h22, 0, 32'd5, 32'd3, 0, 0, 32'd2, 0, 0, 0);
    vec("and",  0, 3'b111, 6'h24, 0, 32'd5, 32'd3, 0, 0, 32'd1, 0, 0, 0);
    vec("or",   1, 3'b111, 6'h25, 0, 32'd5, 32'd3, 0, 0, 32'd7, 0, 0, 0);
    vec("nor",  1, 3'b111, 6'h27, 0, 32'd5, 32'd3, 0, 0, 32'hFFFFFFF8, 0, 0, 0);

    // Immediates and shifts
    vec("addi_wrap", 1, 3'b100, 6'h3F, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 32'h0, 1, 0, 0);
    vec("ori",  1, 3'b101, 6'h00, 0, 32'hF0F00000, 32'h0000000F, 0, 0, 32'hF0F0000F, 0, 0, 0);
    vec("andi", 1, 3'b110, 6'h00, 0, 32'hFF00FF00, 32'h0000FFFF, 0, 0, 32'h0000FF00, 0, 0, 0);
    vec("lui",  1, 3'b011, 6'h00, 0, 32'hDEADBEEF, 32'hFFFF1234, 0, 0, 32'h12340000, 0, 0, 0);
    vec("sll31", 1, 3'b111, 6'h00, 31, 32'h0, 32'd1, 0, 0, 32'h80000000, 0, 0, 0);
    vec("srl4", 1, 3'b111, 6'h02, 4, 32'hFFFFFFFF, 32'h80000000, 0, 0, 32'h08000000, 0, 0, 0);

    // Branches
    vec("beq_take", 1, 3'b001, 6'h00, 0, 32'd9, 32'd9, 1, 0, 32'd0, 1, 1, 0);
    vec("beq_not",  1, 3'b001, 6'h00, 0, 32'd9, 32'd8, 1, 0, 32'd1, 0, 0, 0);
    vec("bne_take", 1, 3'b001, 6'h00, 0, 32'd9, 32'd8, 0, 1, 32'd1, 0, 1, 0);
    vec("bne_not",  1, 3'b001, 6'h00, 0, 32'd7, 32'd7, 0, 1, 32'd0, 1, 0, 0);
    vec("both_eq",  1, 3'b001, 6'h00, 0, 32'd7, 32'd7, 1, 1, 32'd0, 1, 1, 0);
    vec("both_ne",  1, 3'b001, 6'h00, 0, 32'd7, 32'd3, 1, 1, 32'd4, 0, 1, 0);

    // Illegal encodings
    vec("ill_op",    1, 3'b000, 6'h20, 0, 32'd5, 32'd3, 1, 0, 32'd0, 1, 0, 1);
    vec("ill_op2",   1, 3'b010, 6'h20, 0, 32'd5, 32'd3, 0, 1, 32'd0, 1, 0, 1);
    vec("ill_funct", 1, 3'b111, 6'h3F, 0, 32'd5, 32'd3, 0, 0, 32'd0, 1, 0, 1);

`ifdef ALU_OVERFLOW_EN
    vec("ovf_add", 1, 3'b111, 6'h20, 0, 32'h7FFFFFFF, 32'd1, 0, 0, 32'h80000000, 0, 0, 0);
    check("ovf_add.flag", 32'(Overflow), 32'd1);
    vec("ovf_sub", 1, 3'b111, 6'h22, 0, 32'h80000000, 32'd1, 0, 0, 32'h7FFFFFFF, 0, 0, 0);
    check("ovf_sub.flag", 32'(Overflow), 32'd1);
    vec("ovf_none", 1, 3'b100, 6'h00, 0, 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0);
    check("ovf_none.flag", 32'(Overflow), 32'd0);
    vec("ovf_or", 1, 3'b101, 6'h00, 0, 32'h7FFFFFFF, 32'h80000000, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    check("ovf_or.flag", 32'(Overflow), 32'd0);
`endif

    // Mid-cycle reset with nonzero outputs present
    vec("pre_rst", 1, 3'b111, 6'h25, 0, 32'd5, 32'd3, 0, 1, 32'd7, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("rst_release", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("post_rst", 1'b1, 32'd7, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
